window_seq_ctrl: RTL
====================

// Module: window_seq_ctrl
// PURPOSE
//  Frame sequencer for the 3x3 line-buffer window (bufferr). Clears the line buffer at frame
//  start, gates its shift enable with accepted pixels and tracks pixel column/row. Flags the
//  cycles where the 3x3 matrix holds a complete in-frame window and tags it with centre coords.
//  Sits between the pixel source (camera/grey stage) and the window consumers (filter/recognition).
// PARAMETERS
//  IMG_W    640  active pixels per line (>=3)
//  IMG_H    480  active lines per frame (>=3)
//  CLR_CYC  2    cycles buf_aclr is held high at frame start (>=1)
//  CW/RW are localparams = $clog2(IMG_W)/$clog2(IMG_H).
// PORTS
//  clk          in   1   system clock, all logic on rising edge
//  rst          in   1   asynchronous, active-high reset
//  frame_start  in   1   1-cycle pulse: new frame begins (from vsync edge)
//  pix_vld      in   1   pixel present on bufferr per_img_Y this cycle
//  buf_aclr     out  1   to bufferr aclr (line-buffer clear)
//  buf_ien      out  1   to bufferr ien (combinational: pix_vld & state==RUN)
//  win_vld      out  1   matrix_p11..p33 hold a full window this cycle
//  win_col      out  CW  centre column of current window
//  win_row      out  RW  centre row of current window
//  frame_done   out  1   1-cycle pulse, same cycle as last win_vld of frame
//  busy         out  1   state != IDLE
//  drop_err     out  1   sticky: pix_vld seen outside RUN; cleared by frame_start
// BEHAVIOUR
//  Reset: state IDLE; counters 0; all registered outputs 0 (buf_ien 0 since state!=RUN).
//  FSM: IDLE -frame_start-> CLEAR; CLEAR holds CLR_CYC cycles (buf_aclr=1) -> RUN;
//   RUN: each pix_vld advances col; col==IMG_W-1 wraps to 0 and increments row;
//   accepting pixel (IMG_W-1,IMG_H-1) -> DONE; DONE (1 cycle) -> IDLE.
//  frame_start in any state (incl. CLEAR/RUN/DONE): abort, zero counters, enter CLEAR,
//   restart CLR_CYC count. frame_start has priority over a same-cycle pix_vld (pixel dropped,
//   buf_ien=0, drop_err NOT set for that pixel).
//  Pixels in IDLE/CLEAR/DONE: ignored, no shift, counters unchanged, drop_err<=1.
//  Window timing: bufferr matrix registers update on the clock after ien, so a pixel
//   accepted at (col,row) with col>=2 and row>=2 yields win_vld=1 exactly 1 cycle later,
//   win_col=col-1, win_row=row-1. Otherwise win_vld=0 that cycle; win_col/win_row hold.
//  pix_vld gaps: no effect beyond stalling; win_vld never asserts on a non-accept cycle+1.
//  Windows per frame = (IMG_W-2)*(IMG_H-2); windows never straddle a line wrap.
//  frame_done: registered, asserted with the final win_vld (from DONE entry), then 0.
//  Async rst mid-frame: immediate return to reset values; next frame needs frame_start.
//  Counters: col CW bits, row RW bits, compare against IMG_W-1/IMG_H-1 only (no overflow).
// STRUCTURE
//  Package window_seq_pkg: state enum {IDLE,CLEAR,RUN,DONE}, clog2-derived width constants.
//  Sub-module px_counter (col/row counter with inc, clr, wrap and last-pixel flags).
//  Top holds FSM, CLEAR timer, window-valid/coord pipeline register, drop_err.
// TESTING (IMG_W=4, IMG_H=3, CLR_CYC=2)
//  Reset then frame_start -> buf_aclr high 2 cycles, busy=1; then 12 back-to-back pix_vld ->
//   win_vld exactly twice: (col1,row1) then (col2,row1); frame_done with 2nd; then busy=0.
//  Same frame with pix_vld toggling 1/0 -> same 2 windows/coords, each 1 cycle after its pixel.
//  pix_vld during CLEAR -> buf_ien=0, counters 0, drop_err=1; next frame_start clears drop_err.
//  frame_start after 7 pixels in RUN -> CLEAR re-entered, counters 0; full frame after gives 2 windows.
//  frame_start and pix_vld in same RUN cycle -> buf_ien=0, pixel not counted, drop_err stays 0.
//  rst pulsed mid-RUN -> all outputs 0 same cycle; later pixels without frame_start set drop_err.

Source files
------------

// File: rtl/window_seq_pkg.sv
// Shared types and helpers for the 3x3 window frame sequencer.
package window_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int unsigned DEF_IMG_W   = 640;
  localparam int unsigned DEF_IMG_H   = 480;
  localparam int unsigned DEF_CLR_CYC = 2;

  // Width of a timer that counts 0 .. cycles-1 (never narrower than 1 bit).
  function automatic int unsigned timer_w(input int unsigned cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/window_seq_ctrl_px_counter.sv
// Pixel column/row counter with synchronous clear, line wrap and last-pixel flag.
module px_counter #(
  parameter  int unsigned IMG_W = 640,
  parameter  int unsigned IMG_H = 480,
  localparam int unsigned CW    = $clog2(IMG_W),
  localparam int unsigned RW    = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          inc,
  output logic [CW-1:0] col,
  output logic [RW-1:0] row,
  output logic          last_pix
);

  logic col_last;
  logic row_last;

  assign col_last = (col == CW'(IMG_W - 1));
  assign row_last = (row == RW'(IMG_H - 1));
  assign last_pix = col_last & row_last;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (clr) begin
      col <= '0;
      row <= '0;
    end else if (inc) begin
      if (col_last) begin
        col <= '0;
        row <= row_last ? '0 : row + RW'(1);
      end else begin
        col <= col + CW'(1);
      end
    end
  end

endmodule

// File: rtl/window_seq_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window: clears the buffer, gates its
// shift enable and flags cycles where the matrix holds a full in-frame window.
module window_seq_ctrl
  import window_seq_pkg::*;
#(
  parameter  int unsigned IMG_W   = DEF_IMG_W,
  parameter  int unsigned IMG_H   = DEF_IMG_H,
  parameter  int unsigned CLR_CYC = DEF_CLR_CYC,
  localparam int unsigned CW      = $clog2(IMG_W),
  localparam int unsigned RW      = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          frame_start,
  input  logic          pix_vld,
  output logic          buf_aclr,
  output logic          buf_ien,
  output logic          win_vld,
  output logic [CW-1:0] win_col,
  output logic [RW-1:0] win_row,
  output logic          frame_done,
  output logic          busy,
  output logic          drop_err
);

  localparam int unsigned TW = timer_w(CLR_CYC);

  state_t          state;
  state_t          state_nxt;
  logic [TW-1:0]   clr_cnt;
  logic            clr_end;
  logic            accept;
  logic            win_ok;
  logic [CW-1:0]   col;
  logic [RW-1:0]   row;
  logic            last_pix;

  // frame_start wins over a same-cycle pixel: the pixel is not shifted in.
  assign accept  = pix_vld & (state == RUN) & ~frame_start;
  assign buf_ien = accept;
  assign clr_end = (clr_cnt == TW'(CLR_CYC - 1));
  assign win_ok  = (col >= CW'(2)) && (row >= RW'(2));

  px_counter #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_px_counter (
    .clk      (clk),
    .rst      (rst),
    .clr      (frame_start),
    .inc      (accept),
    .col      (col),
    .row      (row),
    .last_pix (last_pix)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    buf_aclr  = 1'b0;
    busy      = 1'b1;
    unique case (state)
      IDLE:  busy = 1'b0;
      CLEAR: begin
        buf_aclr = 1'b1;
        if (clr_end) state_nxt = RUN;
      end
      RUN:   if (accept && last_pix) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
    endcase
    if (frame_start) state_nxt = CLEAR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clr_cnt <= '0;
    end else if (frame_start || state != CLEAR) begin
      clr_cnt <= '0;
    end else if (!clr_end) begin
      clr_cnt <= clr_cnt + TW'(1);
    end
  end

  // The matrix registers update one clock after ien, so the window flag and
  // its centre coordinates trail the accepted pixel by exactly one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_vld    <= 1'b0;
      win_col    <= '0;
      win_row    <= '0;
      frame_done <= 1'b0;
    end else begin
      win_vld    <= accept & win_ok;
      frame_done <= accept & last_pix;
      if (accept && win_ok) begin
        win_col <= col - CW'(1);
        win_row <= row - RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_err <= 1'b0;
    end else if (frame_start) begin
      drop_err <= 1'b0;
    end else if (pix_vld && state != RUN) begin
      drop_err <= 1'b1;
    end
  end

endmodule
